// File: rtl/npu_memctrl_xfer.sv
// rtl/npu_memctrl_xfer.sv - DDR burst responder for NPU master-control and OR-dataflow transfer states
module npu_memctrl_xfer #(
   parameter int DDR_AW = 32,
   parameter int DW     = 128,
   parameter int LW     = 16
) (
   input  logic              clk_trans,
   input  logic              rst,
   input  logic [6:0]        mc_cs,
   input  logic [5:0]        or_cs,
   input  logic [7:0]        nn_layers_cnt,
   input  logic [11:0]       ft_Mt_cnt,
   input  logic [7:0]        ft_Nt_cnt,
   input  logic [10:0]       ft_IYt_cnt,
   input  logic [7:0]        tx_Nt_cnt,
   input  logic [11:0]       tx_OYt_cnt,
   input  logic [11:0]       Mt_times,
   input  logic [10:0]       IYt_times,
   input  logic [DDR_AW-1:0] nn_rd_ifm_saddr,
   input  logic [DDR_AW-1:0] nn_wr_ofm_saddr,
   input  logic [DDR_AW-1:0] para_saddr,
   input  logic [DDR_AW-1:0] bn_saddr,
   input  logic [DDR_AW-1:0] wt_saddr,
   input  logic [LW-1:0]     para_words,
   input  logic [LW-1:0]     bn_words,
   input  logic [LW-1:0]     ifm_tile_words,
   input  logic [LW-1:0]     wt_tile_words,
   input  logic [LW-1:0]     ofm_tile_words,
   output logic              ddr_cmd_valid,
   input  logic              ddr_cmd_ready,
   output logic              ddr_cmd_wr,
   output logic [DDR_AW-1:0] ddr_cmd_addr,
   output logic [LW-1:0]     ddr_cmd_len,
   input  logic              ddr_rd_valid,
   input  logic [DW-1:0]     ddr_rd_data,
   output logic              ddr_wr_valid,
   input  logic              ddr_wr_ready,
   output logic [DW-1:0]     ddr_wr_data,
   input  logic              ddr_wr_ack,
   input  logic              ofm_valid,
   output logic              ofm_ready,
   input  logic [DW-1:0]     ofm_data,
   output logic              buf_wr_en,
   output logic [1:0]        buf_wr_sel,
   output logic [LW-1:0]     buf_wr_addr,
   output logic [DW-1:0]     buf_wr_data,
   output logic              ft_lyr_para_done,
   output logic              ft_bn_done,
   output logic              ft_ifm_done,
   output logic              ft_wt_done,
   output logic              tx_ofm_done,
   output logic              xfer_err
);
   localparam int SH = $clog2(DW / 8);

   typedef enum logic [2:0] {X_IDLE, X_CMD, X_RD, X_WR, X_DONE} xstate_t;

   // Job codes double as trigger-vector bit index and, for reads, buffer select
   localparam logic [2:0] J_PARA = 3'd0;
   localparam logic [2:0] J_BN   = 3'd1;
   localparam logic [2:0] J_IFM  = 3'd2;
   localparam logic [2:0] J_WT   = 3'd3;
   localparam logic [2:0] J_OFM  = 3'd4;

   xstate_t           r_state;
   xstate_t           w_next;
   logic [4:0]        r_trig_prev;
   logic [2:0]        r_job;
   logic              r_wr;
   logic [DDR_AW-1:0] r_addr;
   logic [LW-1:0]     r_len;
   logic [LW-1:0]     r_cnt;
   logic              r_ack_seen;
   logic              r_err;

   logic [4:0]        w_trig;
   logic [4:0]        w_edge;
   logic              w_any;
   logic              w_multi;
   logic [2:0]        w_sel_job;
   logic [DDR_AW-1:0] w_job_addr;
   logic [LW-1:0]     w_job_len;
   logic [DDR_AW-1:0] w_para_idx;
   logic [DDR_AW-1:0] w_ifm_idx;
   logic [DDR_AW-1:0] w_wt_idx;
   logic [DDR_AW-1:0] w_ofm_idx;
   logic              w_beats_left;
   logic              w_wr_acc;
   logic              w_inc;
   logic [LW-1:0]     w_cnt_inc;
   logic              w_cnt_full;
   logic              w_err_set;
   logic              w_unused_bits;

   assign w_trig  = {or_cs[4], or_cs[2], or_cs[1], mc_cs[3], mc_cs[2]};
   assign w_edge  = w_trig & ~r_trig_prev;
   assign w_any   = |w_edge;
   assign w_multi = (w_edge & (w_edge - 5'd1)) != 5'd0;
   assign w_unused_bits = ^{mc_cs[6:4], mc_cs[1:0], or_cs[5], or_cs[3], or_cs[0]};

   assign w_para_idx = DDR_AW'(nn_layers_cnt) * DDR_AW'(para_words);
   assign w_ifm_idx  = (DDR_AW'(ft_IYt_cnt) * DDR_AW'(Mt_times) + DDR_AW'(ft_Mt_cnt))
                       * DDR_AW'(ifm_tile_words);
   assign w_wt_idx   = (DDR_AW'(ft_Nt_cnt) * DDR_AW'(Mt_times) + DDR_AW'(ft_Mt_cnt))
                       * DDR_AW'(wt_tile_words);
   assign w_ofm_idx  = (DDR_AW'(tx_Nt_cnt) * DDR_AW'(IYt_times) + DDR_AW'(tx_OYt_cnt))
                       * DDR_AW'(ofm_tile_words);

   always_comb begin
      w_sel_job  = J_OFM;
      w_job_addr = '0;
      w_job_len  = '0;
      if (w_edge[0])      w_sel_job = J_PARA;
      else if (w_edge[1]) w_sel_job = J_BN;
      else if (w_edge[2]) w_sel_job = J_IFM;
      else if (w_edge[3]) w_sel_job = J_WT;
      case (w_sel_job)
         J_PARA: begin w_job_addr = para_saddr + (w_para_idx << SH);      w_job_len = para_words;     end
         J_BN:   begin w_job_addr = bn_saddr;                             w_job_len = bn_words;       end
         J_IFM:  begin w_job_addr = nn_rd_ifm_saddr + (w_ifm_idx << SH);  w_job_len = ifm_tile_words; end
         J_WT:   begin w_job_addr = wt_saddr + (w_wt_idx << SH);          w_job_len = wt_tile_words;  end
         default: begin w_job_addr = nn_wr_ofm_saddr + (w_ofm_idx << SH); w_job_len = ofm_tile_words; end
      endcase
   end

   // Write beats stop being offered once the burst is full, even if the PEs keep pushing
   assign w_beats_left = (r_cnt != r_len);
   assign w_wr_acc     = (r_state == X_WR) && ofm_valid && ddr_wr_ready && w_beats_left;
   assign w_inc        = ((r_state == X_RD) && ddr_rd_valid) || w_wr_acc;
   assign w_cnt_inc    = r_cnt + {{(LW-1){1'b0}}, w_inc};
   assign w_cnt_full   = (w_cnt_inc == r_len);

   assign w_err_set = (ddr_rd_valid && (r_state != X_RD))
                   || (ddr_wr_ack && (r_state == X_WR) && !w_cnt_full)
                   || (ddr_wr_ack && (r_state == X_CMD) && r_wr)
                   || (w_any && (r_state != X_IDLE))
                   || (w_multi && (r_state == X_IDLE));

   always_ff @(posedge clk_trans) begin
      if (rst) r_state <= X_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         X_IDLE: if (w_any) w_next = (w_job_len == '0) ? X_DONE : X_CMD;
         X_CMD:  if (ddr_cmd_ready) w_next = r_wr ? X_WR : X_RD;
         X_RD:   if (ddr_rd_valid && w_cnt_full) w_next = X_DONE;
         X_WR:   if (w_cnt_full && (r_ack_seen || ddr_wr_ack)) w_next = X_DONE;
         X_DONE: w_next = X_IDLE;
         default: w_next = X_IDLE;
      endcase
   end

   always_ff @(posedge clk_trans) begin
      if (rst) begin
         r_trig_prev <= '0;
         r_job       <= J_PARA;
         r_wr        <= 1'b0;
         r_addr      <= '0;
         r_len       <= '0;
         r_cnt       <= '0;
         r_ack_seen  <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_trig_prev <= w_trig;
         if (w_err_set) r_err <= 1'b1;
         if ((r_state == X_IDLE) && w_any) begin
            r_job      <= w_sel_job;
            r_wr       <= (w_sel_job == J_OFM);
            r_addr     <= w_job_addr;
            r_len      <= w_job_len;
            r_cnt      <= '0;
            r_ack_seen <= 1'b0;
         end else begin
            if (w_inc) r_cnt <= w_cnt_inc;
            if ((r_state == X_WR) && ddr_wr_ack) r_ack_seen <= 1'b1;
         end
      end
   end

   always_comb begin
      ddr_cmd_valid    = 1'b0;
      ddr_cmd_wr       = 1'b0;
      ddr_cmd_addr     = '0;
      ddr_cmd_len      = '0;
      ddr_wr_valid     = 1'b0;
      ddr_wr_data      = '0;
      ofm_ready        = 1'b0;
      buf_wr_en        = 1'b0;
      buf_wr_sel       = 2'd0;
      buf_wr_addr      = '0;
      buf_wr_data      = '0;
      ft_lyr_para_done = 1'b0;
      ft_bn_done       = 1'b0;
      ft_ifm_done      = 1'b0;
      ft_wt_done       = 1'b0;
      tx_ofm_done      = 1'b0;
      case (r_state)
         X_CMD: begin
            ddr_cmd_valid = 1'b1;
            ddr_cmd_wr    = r_wr;
            ddr_cmd_addr  = r_addr;
            ddr_cmd_len   = r_len;
         end
         X_RD: begin
            if (ddr_rd_valid) begin
               buf_wr_en   = 1'b1;
               buf_wr_sel  = r_job[1:0];
               buf_wr_addr = r_cnt;
               buf_wr_data = ddr_rd_data;
            end
         end
         X_WR: begin
            ddr_wr_valid = ofm_valid && w_beats_left;
            ofm_ready    = ddr_wr_ready && w_beats_left;
            ddr_wr_data  = ofm_data;
         end
         X_DONE: begin
            case (r_job)
               J_PARA:  ft_lyr_para_done = 1'b1;
               J_BN:    ft_bn_done       = 1'b1;
               J_IFM:   ft_ifm_done      = 1'b1;
               J_WT:    ft_wt_done       = 1'b1;
               default: tx_ofm_done      = 1'b1;
            endcase
         end
         default: ;
      endcase
   end

   assign xfer_err = r_err;
endmodule

// File: doc/npu_memctrl_xfer.md
# npu_memctrl_xfer

Memory-transfer responder for the SEU NPU. It watches the master-control and OR-dataflow state vectors and loop counters driven by the NPU master control unit. On each state entry it issues one DDR burst: a read for layer parameters, BN, IFM tile or weight tile, or a write for an OFM tile. When the burst finishes it returns the matching single-cycle done pulse (`ft_lyr_para_done`, `ft_bn_done`, `ft_ifm_done`, `ft_wt_done`, `tx_ofm_done`). It sits between the master control unit, the PE-side buffers and the DDR command port.

## Interface
Clock and reset: one clock; reset is synchronous and active-high.

Parameters:
- `DDR_AW`, 32: DDR byte-address width.
- `DW`, 128: DDR data width; beat = DW/8 bytes; address offset = beats << log2(DW/8).
- `LW`, 16: burst length / beat-count width.

Ports:
- `clk_trans` in 1: clock.
- `rst` in 1: synchronous active-high reset.
- `mc_cs` in 7: master state, one-hot (bit 2 FT_PARA, bit 3 FT_BN).
- `or_cs` in 6: OR-dataflow state, one-hot (bit 1 FT_IFM, bit 2 FT_WT, bit 4 TX_OFM).
- `nn_layers_cnt` in 8: current layer index.
- `ft_Mt_cnt` in 12, `ft_Nt_cnt` in 8, `ft_IYt_cnt` in 11, `tx_Nt_cnt` in 8, `tx_OYt_cnt` in 12: loop counters.
- `Mt_times` in 12, `IYt_times` in 11: tile counts.
- `nn_rd_ifm_saddr`, `nn_wr_ofm_saddr`, `para_saddr`, `bn_saddr`, `wt_saddr` in DDR_AW: base addresses.
- `para_words`, `bn_words`, `ifm_tile_words`, `wt_tile_words`, `ofm_tile_words` in LW: burst lengths in beats.
- `ddr_cmd_valid` out 1, `ddr_cmd_ready` in 1, `ddr_cmd_wr` out 1, `ddr_cmd_addr` out DDR_AW, `ddr_cmd_len` out LW: command handshake.
- `ddr_rd_valid` in 1, `ddr_rd_data` in DW: read beats (no backpressure).
- `ddr_wr_valid` out 1, `ddr_wr_ready` in 1, `ddr_wr_data` out DW, `ddr_wr_ack` in 1: write beats and completion pulse.
- `ofm_valid` in 1, `ofm_ready` out 1, `ofm_data` in DW: OFM stream from PEs.
- `buf_wr_en` out 1, `buf_wr_sel` out 2 (0 para, 1 bn, 2 ifm, 3 wt), `buf_wr_addr` out LW, `buf_wr_data` out DW: on-chip buffer write.
- `ft_lyr_para_done`, `ft_bn_done`, `ft_ifm_done`, `ft_wt_done`, `tx_ofm_done` out 1: done pulses.
- `xfer_err` out 1: sticky protocol-error flag.

## Operation
- **Job start.** A job starts on the rising edge of its trigger bit: the bit is high now and was low in the previous (registered) cycle.
- **Job types, addresses and lengths** (all arithmetic truncated to DDR_AW):
  - PARA (`mc_cs[2]`): `para_saddr + nn_layers_cnt*para_words`, length `para_words`.
  - BN (`mc_cs[3]`): `bn_saddr`, length `bn_words`.
  - IFM (`or_cs[1]`): `nn_rd_ifm_saddr + (ft_IYt_cnt*Mt_times + ft_Mt_cnt)*ifm_tile_words`.
  - WT (`or_cs[2]`): `wt_saddr + (ft_Nt_cnt*Mt_times + ft_Mt_cnt)*wt_tile_words`.
  - OFM (`or_cs[4]`): `nn_wr_ofm_saddr + (tx_Nt_cnt*IYt_times + tx_OYt_cnt)*ofm_tile_words`, with `ddr_cmd_wr=1`.
  - Counters and bases are captured at the start edge.
- **FSM states.** X_IDLE, X_CMD, X_RD, X_WR, X_DONE.
  - X_IDLE: on a start edge, latch the job and go to X_CMD. If length is 0, go straight to X_DONE.
  - X_CMD: hold `ddr_cmd_valid` with stable fields until `ddr_cmd_ready`, then go to X_RD (read) or X_WR (write).
  - X_RD: every `ddr_rd_valid` beat produces `buf_wr_en=1`, `buf_wr_sel` = job type, `buf_wr_addr` = beat index starting at 0, and `buf_wr_data` = `ddr_rd_data`, all combinational. The beat that makes the count equal the length moves to X_DONE.
  - X_WR: `ddr_wr_valid = ofm_valid`, `ofm_ready = ddr_wr_ready`, `ddr_wr_data = ofm_data`. Count accepted beats. Go to X_DONE once all beats are accepted and `ddr_wr_ack` has been seen (the ack may arrive on the final-beat cycle or later).
  - X_DONE: pulse the job's done output for exactly one cycle, then return to X_IDLE.
- **Errors.** `xfer_err` sets and stays set (until reset) on any of:
  - `ddr_rd_valid` outside X_RD;
  - `ddr_wr_ack` before the last write beat;
  - a start edge while not in X_IDLE. That edge is dropped.
- **Simultaneous start edges** in X_IDLE take priority PARA > BN > IFM > WT > OFM; the others are dropped and `xfer_err` sets.

## Timing
- **Reset values.** All outputs are 0; the FSM is in X_IDLE; edge-detect registers are 0.
- **Reset mid-job.** Reset abandons the job with no done pulse; beats arriving afterwards set `xfer_err` only if they arrive after reset releases.
- **Command issue.** A start edge seen in cycle T gives `ddr_cmd_valid=1` in T+1.
- **Done latency.** With the final read beat in cycle R, the done pulse is in R+1. For writes, the pulse is 1 cycle after the later of the last beat and the ack. With zero length, the pulse is in T+1 and no command is issued.
- **Back-to-back jobs.** The earliest following start edge can be accepted in the cycle after the done pulse.

## Test plan
- **PARA read:** `para_saddr=0x1000`, `nn_layers_cnt=2`, `para_words=4`, DW=128, `mc_cs` 0x2→0x4 → command addr 0x1080, len 4, wr=0; beats land on `buf_wr_sel=0`, addr 0..3; `ft_lyr_para_done` pulses 1 cycle after beat 3.
- **Backpressure:** `ddr_cmd_ready` low for 5 cycles → `ddr_cmd_valid` and fields stay stable; no done pulse.
- **WT read:** `ft_Nt_cnt=1`, `Mt_times=3`, `ft_Mt_cnt=2`, `wt_tile_words=8` → addr = `wt_saddr` + 0x280; `ft_wt_done` pulses once.
- **OFM write:** 6 beats with `ofm_valid` and `ddr_wr_ready` toggling, ack 3 cycles after the last beat → exactly 6 beats transferred; `tx_ofm_done` pulses 1 cycle after the ack.
- **Zero-length BN:** `bn_words=0` → no command; `ft_bn_done` in T+1.
- **Errors and reset:** a read beat in X_IDLE → `xfer_err=1` and sticky; `rst` asserted mid-X_RD → all outputs 0 the next cycle and no done pulse.
